// File: rtl/jk_bank_driver_pkg.sv
// Shared encodings for JK-bank drivers and the microcode decode that feeds them.
package jk_bank_driver_pkg;

    // Word-level operation requested of a JK flop bank.
    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    // Driver sequencing: one excitation cycle, then one readback cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_e;

    localparam int JK_DEF_WIDTH = 8;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request/readback bundle between register control, the driver and the flop bank.
// Q_FB sits on the master side because the controller side also owns the bank wiring.
interface jk_bank_driver_if
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH = JK_DEF_WIDTH
);
    logic             REQ;
    op_e              OP;
    logic [WIDTH-1:0] TARGET;
    logic [WIDTH-1:0] Q_FB;
    logic             ERR_CLR;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             BUSY;
    logic             ACK;
    logic             ERR;
    logic [WIDTH-1:0] EXPECT;

    modport master (
        output REQ, OP, TARGET, Q_FB, ERR_CLR,
        input  J, K, BUSY, ACK, ERR, EXPECT
    );

    modport slave (
        input  REQ, OP, TARGET, Q_FB, ERR_CLR,
        output J, K, BUSY, ACK, ERR, EXPECT
    );
endinterface

// File: rtl/jk_bank_driver_excite.sv
// Per-bit J/K excitation and predicted Q for one word-level op on a JK bank.
// Purely combinational so other bank drivers can reuse it.
module jk_excite
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH = JK_DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] expect_q
);

    // TARGET acts as the load value for LOAD and as a bit mask otherwise.
    always_comb begin
        j        = '0;
        k        = '0;
        expect_q = q0;
        unique case (op)
            OP_LOAD: begin
                j        = target;
                k        = ~target;
                expect_q = target;
            end
            OP_SET: begin
                j        = target;
                expect_q = q0 | target;
            end
            OP_CLEAR: begin
                k        = target;
                expect_q = q0 & ~target;
            end
            OP_TOGGLE: begin
                j        = target;
                k        = target;
                expect_q = q0 ^ target;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Sequences one JK-bank op: excite for one cycle, read Q back, ACK and flag mismatches.
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH    = JK_DEF_WIDTH,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    jk_bank_driver_if.slave bus
);

    state_e           state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] exc_j, exc_k, exc_expect;
    logic [WIDTH-1:0] j_q, k_q, expect_q;
    logic             ack_q, err_q;
    logic             mismatch;

    // Q_FB at accept time is the pre-op snapshot Q0; it is only consumed on that edge.
    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .op       (bus.OP),
        .target   (bus.TARGET),
        .q0       (bus.Q_FB),
        .j        (exc_j),
        .k        (exc_k),
        .expect_q (exc_expect)
    );

    // State register; reset parks the driver in IDLE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: REQ is looked at only in IDLE, so requests while busy are dropped.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    accept  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign mismatch = CHECK_EN && (state_q == ST_CHECK) && (bus.Q_FB != expect_q);

    // J/K are nonzero only for the DRIVE cycle; EXPECT holds until the next accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            j_q      <= '0;
            k_q      <= '0;
            expect_q <= '0;
        end else begin
            j_q <= accept ? exc_j : '0;
            k_q <= accept ? exc_k : '0;
            if (accept) expect_q <= exc_expect;
        end
    end

    // ACK follows the CHECK exit edge; a mismatch outranks a same-cycle ERR_CLR.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= (state_q == ST_CHECK);
            if (mismatch)         err_q <= 1'b1;
            else if (bus.ERR_CLR) err_q <= 1'b0;
        end
    end

    assign bus.J      = j_q;
    assign bus.K      = k_q;
    assign bus.EXPECT = expect_q;
    assign bus.ACK    = ack_q;
    assign bus.ERR    = err_q;
    assign bus.BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a behavioural JK bank closes the Q_FB loop, and a
// word-level model predicts bank contents from the op definitions.
module tb_jk_bank_driver;
    import jk_bank_driver_pkg::*;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLK = ~CLK;

    jk_bank_driver_if #(.WIDTH(8)) bif ();
    jk_bank_driver_if #(.WIDTH(8)) bif1 ();

    jk_bank_driver #(.WIDTH(8), .CHECK_EN(1'b1)) u_dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bif));
    jk_bank_driver #(.WIDTH(8), .CHECK_EN(1'b0)) u_dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bif1));

    // Master-slave JK bank: master samples on posedge, Q follows on negedge.
    // rn0 models an async R_N pulse on bit 0 arriving around the negedge.
    logic [7:0] bank_m = 8'h00;
    logic [7:0] bank_q = 8'h00;
    bit         rn0    = 1'b0;
    always @(posedge CLK) bank_m <= (bif.J & ~bank_q) | (~bif.K & bank_q);
    always @(negedge CLK) bank_q <= rn0 ? (bank_m & 8'hFE) : bank_m;
    assign bif.Q_FB = bank_q;

    int tests = 0;
    int fails = 0;
    logic [7:0] model_q = 8'h00;

    logic [7:0] o_j, o_k, o_jmid, o_kmid, o_jchk, o_kchk, o_exp, o_qfb;
    logic       o_busy_drv, o_busy_chk, o_err, o_busy_ack, o_ack_after;
    int         o_lat;

    // Word-level meaning of each op on the bank contents.
    function automatic logic [7:0] ref_next(input logic [1:0] op, input logic [7:0] q, input logic [7:0] t);
        case (op)
            2'd0:    return t;
            2'd1:    return q | t;
            2'd2:    return q & ~t;
            default: return q ^ t;
        endcase
    endfunction

    function automatic logic [7:0] ref_j(input logic [1:0] op, input logic [7:0] t);
        return (op == 2'd2) ? 8'h00 : t;
    endfunction

    function automatic logic [7:0] ref_k(input logic [1:0] op, input logic [7:0] t);
        case (op)
            2'd0:    return ~t;
            2'd1:    return 8'h00;
            default: return t;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one op on the main DUT and records what it saw; o_lat counts edges from accept to ACK.
    task automatic drive_op(input logic [1:0] op, input logic [7:0] t, input bit rn, input bit clr);
        bif.REQ = 1'b1; bif.OP = op_e'(op); bif.TARGET = t;
        tick();
        o_j = bif.J; o_k = bif.K; o_busy_drv = bif.BUSY;
        bif.REQ = 1'b0; bif.TARGET = ~t; bif.OP = op_e'(~op);
        #3;
        o_jmid = bif.J; o_kmid = bif.K;
        tick();
        o_jchk = bif.J; o_kchk = bif.K; o_busy_chk = bif.BUSY;
        if (rn)  rn0 = 1'b1;
        if (clr) bif.ERR_CLR = 1'b1;
        @(negedge CLK);
        #1;
        rn0 = 1'b0;
        o_qfb = bif.Q_FB;
        o_lat = 1;
        while (o_lat < 8) begin
            tick();
            o_lat++;
            if (bif.ACK) break;
        end
        o_err = bif.ERR; o_exp = bif.EXPECT; o_busy_ack = bif.BUSY;
        bif.ERR_CLR = 1'b0;
        tick();
        o_ack_after = bif.ACK;
    endtask

    task automatic test_reset();
        #2;
        tests++; if ({bif.J, bif.K} !== 16'h0000) begin fails++; $display("FAIL reset_jk: got %h want 0000", {bif.J, bif.K}); end
        tests++; if ({bif.BUSY, bif.ACK, bif.ERR} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bif.BUSY, bif.ACK, bif.ERR}); end
        tests++; if (bif.EXPECT !== 8'h00) begin fails++; $display("FAIL reset_expect: got %h want 00", bif.EXPECT); end
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        tests++; if (bif.BUSY !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", bif.BUSY); end
    endtask

    task automatic test_reset_mid_drive();
        bif.REQ = 1'b1; bif.OP = OP_LOAD; bif.TARGET = 8'hA5;
        tick();
        bif.REQ = 1'b0;
        tests++; if ({bif.J, bif.K} !== 16'hA55A) begin fails++; $display("FAIL middrive_jk_before: got %h want a55a", {bif.J, bif.K}); end
        #2;
        RESET_N = 1'b0;
        #1;
        tests++; if ({bif.J, bif.K} !== 16'h0000) begin fails++; $display("FAIL middrive_jk_drop: got %h want 0000", {bif.J, bif.K}); end
        tests++; if ({bif.BUSY, bif.ERR} !== 2'b00) begin fails++; $display("FAIL middrive_busy_err: got %b want 00", {bif.BUSY, bif.ERR}); end
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        tests++; if ({bif.BUSY, bif.ACK, bif.J} !== 10'h000) begin fails++; $display("FAIL middrive_idle: got %h want 000", {bif.BUSY, bif.ACK, bif.J}); end
        tick();
        tests++; if (bif.ACK !== 1'b0) begin fails++; $display("FAIL middrive_no_ack: got %b want 0", bif.ACK); end
        tests++; if (bif.Q_FB !== model_q) begin fails++; $display("FAIL middrive_bank: got %h want %h", bif.Q_FB, model_q); end
    endtask

    task automatic test_load();
        drive_op(2'd0, 8'hA5, 1'b0, 1'b0);
        model_q = 8'hA5;
        tests++; if ({o_j, o_k} !== 16'hA55A) begin fails++; $display("FAIL load_jk: got %h want a55a", {o_j, o_k}); end
        tests++; if ({o_jmid, o_kmid} !== 16'hA55A) begin fails++; $display("FAIL load_jk_target_change: got %h want a55a", {o_jmid, o_kmid}); end
        tests++; if ({o_jchk, o_kchk} !== 16'h0000) begin fails++; $display("FAIL load_jk_check: got %h want 0000", {o_jchk, o_kchk}); end
        tests++; if ({o_busy_drv, o_busy_chk, o_busy_ack} !== 3'b110) begin fails++; $display("FAIL load_busy: got %b want 110", {o_busy_drv, o_busy_chk, o_busy_ack}); end
        tests++; if (o_qfb !== 8'hA5) begin fails++; $display("FAIL load_qfb: got %h want a5", o_qfb); end
        tests++; if (o_lat !== 2) begin fails++; $display("FAIL load_ack_latency: got %0d want 2", o_lat); end
        tests++; if ({o_err, o_ack_after} !== 2'b00) begin fails++; $display("FAIL load_err_ackpulse: got %b want 00", {o_err, o_ack_after}); end
        tests++; if (o_exp !== 8'hA5) begin fails++; $display("FAIL load_expect: got %h want a5", o_exp); end
    endtask

    task automatic test_set_clear_toggle();
        logic [1:0] ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] tgt [4] = '{8'h0F, 8'h30, 8'h03, 8'hFF};
        logic [7:0] exq [4] = '{8'h0F, 8'h3F, 8'h3C, 8'hC3};
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], tgt[i], 1'b0, 1'b0);
            tests++; if (o_exp !== exq[i]) begin fails++; $display("FAIL sct_expect[%0d]: got %h want %h", i, o_exp, exq[i]); end
            tests++; if (o_qfb !== exq[i]) begin fails++; $display("FAIL sct_qfb[%0d]: got %h want %h", i, o_qfb, exq[i]); end
            tests++; if ({o_err, o_lat[3:0]} !== 5'b0_0010) begin fails++; $display("FAIL sct_err_lat[%0d]: got err=%b lat=%0d want 0/2", i, o_err, o_lat); end
        end
        model_q = 8'hC3;
    endtask

    task automatic test_err_sticky();
        drive_op(2'd0, 8'h00, 1'b0, 1'b0);
        drive_op(2'd3, 8'h01, 1'b1, 1'b1);
        model_q = 8'h00;
        tests++; if ({o_exp, o_qfb} !== 16'h0100) begin fails++; $display("FAIL err_exp_qfb: got %h want 0100", {o_exp, o_qfb}); end
        tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b want 1", o_err); end
        tick();
        tests++; if (bif.ERR !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bif.ERR); end
        bif.ERR_CLR = 1'b1;
        tick();
        bif.ERR_CLR = 1'b0;
        tests++; if (bif.ERR !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", bif.ERR); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [9];
        logic [7:0] tgt [9];
        int acks = 0;
        for (int i = 0; i < 9; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            tgt[i] = 8'($urandom);
            bif.REQ = 1'b1; bif.OP = op_e'(ops[i]); bif.TARGET = tgt[i];
            tick();
            if (bif.ACK) acks++;
        end
        bif.REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bif.ACK) acks++;
        end
        // Ops are taken every third edge while REQ stays high.
        for (int i = 0; i < 9; i += 3) model_q = ref_next(ops[i], model_q, tgt[i]);
        tests++; if (acks !== 3) begin fails++; $display("FAIL b2b_ack_count: got %0d want 3", acks); end
        tests++; if (bif.Q_FB !== model_q) begin fails++; $display("FAIL b2b_bank: got %h want %h", bif.Q_FB, model_q); end
        tests++; if (bif.EXPECT !== model_q) begin fails++; $display("FAIL b2b_expect: got %h want %h", bif.EXPECT, model_q); end
    endtask

    task automatic test_req_busy();
        logic [1:0] op1 = 2'($urandom_range(0, 3));
        logic [7:0] t1  = 8'($urandom);
        int acks = 0;
        bif.REQ = 1'b1; bif.OP = op_e'(op1); bif.TARGET = t1;
        tick();
        bif.OP = op_e'(~op1); bif.TARGET = ~t1;
        tick();
        tick();
        if (bif.ACK) acks++;
        bif.REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bif.ACK) acks++;
        end
        model_q = ref_next(op1, model_q, t1);
        tests++; if (acks !== 1) begin fails++; $display("FAIL busy_ack_count: got %0d want 1", acks); end
        tests++; if (bif.Q_FB !== model_q) begin fails++; $display("FAIL busy_bank: got %h want %h", bif.Q_FB, model_q); end
        tests++; if (bif.EXPECT !== model_q) begin fails++; $display("FAIL busy_expect: got %h want %h", bif.EXPECT, model_q); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [7:0] t  = 8'($urandom);
            logic [7:0] nq = ref_next(op, model_q, t);
            drive_op(op, t, 1'b0, 1'b0);
            tests++; if ({o_j, o_k} !== {ref_j(op, t), ref_k(op, t)}) begin fails++; $display("FAIL rnd_jk[%0d]: op=%0d t=%h got %h want %h", i, op, t, {o_j, o_k}, {ref_j(op, t), ref_k(op, t)}); end
            tests++; if (o_exp !== nq) begin fails++; $display("FAIL rnd_expect[%0d]: got %h want %h", i, o_exp, nq); end
            tests++; if (o_qfb !== nq) begin fails++; $display("FAIL rnd_qfb[%0d]: got %h want %h", i, o_qfb, nq); end
            tests++; if ({o_err, o_ack_after} !== 2'b00 || o_lat != 2) begin fails++; $display("FAIL rnd_err_lat[%0d]: err=%b ack_after=%b lat=%0d want 0/0/2", i, o_err, o_ack_after, o_lat); end
            model_q = nq;
        end
    endtask

    task automatic test_check_disabled();
        int lat = 0;
        bif1.Q_FB = 8'h00;
        bif1.REQ = 1'b1; bif1.OP = OP_LOAD; bif1.TARGET = 8'hFF;
        tick();
        bif1.REQ = 1'b0;
        while (lat < 8) begin
            tick();
            lat++;
            if (bif1.ACK) break;
        end
        tests++; if (lat !== 2) begin fails++; $display("FAIL nochk_ack_latency: got %0d want 2", lat); end
        tests++; if (bif1.EXPECT !== 8'hFF) begin fails++; $display("FAIL nochk_expect: got %h want ff", bif1.EXPECT); end
        tests++; if (bif1.ERR !== 1'b0) begin fails++; $display("FAIL nochk_err: got %b want 0", bif1.ERR); end
        tick();
        tests++; if (bif1.ERR !== 1'b0) begin fails++; $display("FAIL nochk_err_later: got %b want 0", bif1.ERR); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bif.REQ = 1'b0; bif.OP = OP_LOAD; bif.TARGET = 8'h00; bif.ERR_CLR = 1'b0;
        bif1.REQ = 1'b0; bif1.OP = OP_LOAD; bif1.TARGET = 8'h00; bif1.ERR_CLR = 1'b0; bif1.Q_FB = 8'h00;
        #1 RESET_N = 1'b0;
        test_reset();
        test_reset_mid_drive();
        test_load();
        test_set_clear_toggle();
        test_err_sticky();
        test_back_to_back();
        test_req_busy();
        test_random();
        test_check_disabled();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
